// File: rtl/iob_ram_port_ctrl.sv
// Initiator side of one byte-enabled RAM port (1-cycle read latency, read-first RAM).
// Turns a valid/ready request channel into RAM en/we/addr/din cycles and returns read
// data on a valid/ready response channel, with an optional zero-fill after reset.
module iob_ram_port_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  busy,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int unsigned NB = DATA_W / 8;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic run;
  logic accept;
  logic rd_accept;

  // Handshake decode; the response is served straight from ram_dout in the cycle after
  // the read and from the hold register once the consumer has stalled.
  assign run       = (state_q == ST_RUN);
  assign busy      = !run;
  assign rsp_valid = pending_q | hold_vld_q;
  assign rsp_rdata = hold_vld_q ? hold_q : (pending_q ? ram_dout : '0);
  assign req_ready = run && !(rsp_valid && !rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && (req_wstrb == '0);

  // Sequencing: one START cycle, optional full-depth zero fill, then RUN forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_START: begin
        state_d = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_MAX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // Response tracking: capture ram_dout only if the first response cycle is not taken.
  always_comb begin
    pending_d  = rd_accept;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pending_q && !rsp_ready) begin
      hold_vld_d = 1'b1;
      hold_d     = ram_dout;
    end else if (rsp_ready) begin
      hold_vld_d = 1'b0;
    end
  end

  // RAM port drive: fill pattern during INIT, accepted request in RUN, idle otherwise.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (state_q == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = {NB{1'b1}};
      ram_addr = cnt_q;
    end else if (accept) begin
      ram_en   = 1'b1;
      ram_we   = req_wstrb;
      ram_addr = req_addr;
      ram_din  = req_wdata;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_START;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_iob_ram_port_ctrl.sv
// Bench for iob_ram_port_ctrl: byte-enable read-first RAM model, reference memory and a
// response scoreboard; a second instance covers the configuration without zero fill.
module tb_iob_ram_port_ctrl;

  logic        clk;
  logic        arst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        arst0_n;
  logic        req_valid0;
  logic        req_ready0;
  logic [3:0]  req_addr0;
  logic [3:0]  req_wstrb0;
  logic [31:0] req_wdata0;
  logic        rsp_valid0;
  logic        rsp_ready0;
  logic [31:0] rsp_rdata0;
  logic        busy0;
  logic        ram_en0;
  logic [3:0]  ram_we0;
  logic [3:0]  ram_addr0;
  logic [31:0] ram_din0;
  logic [31:0] ram_dout0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] sb_q    [$];
  logic [31:0] last_rdata;
  int          rsp_cnt;
  int          ram0_en_cnt;
  int          n_cmp;
  int          n_err;

  iob_ram_port_ctrl #(.ADDR_W(4), .DATA_W(32), .INIT_CLEAR(1)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  iob_ram_port_ctrl #(.ADDR_W(4), .DATA_W(32), .INIT_CLEAR(0)) dut0 (
    .clk(clk), .arst_n(arst0_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .req_wstrb(req_wstrb0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .busy(busy0), .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_din(ram_din0), .ram_dout(ram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first byte-enable RAM; contents are scrambled while reset is held and dout is
  // garbage except in the cycle after an enable.
  always @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h5A5A_0000 | 32'(i);
      ram_dout <= 32'hBAD0_BAD0;
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= 32'hBAD0_BAD0;
    end
  end

  assign ram_dout0 = 32'h0;
  always @(posedge clk) if (ram_en0) ram0_en_cnt <= ram0_en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One RUN cycle: drive, check against the model just after the negedge, update model.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic rr);
    logic exp_vld;
    logic exp_rdy;
    req_valid = v; req_addr = a; req_wstrb = s; req_wdata = d; rsp_ready = rr;
    #1;
    exp_vld = (sb_q.size() != 0);
    exp_rdy = !(exp_vld && !rr);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_vld) chk("rsp_rdata", rsp_rdata, sb_q[0]);
    if (exp_vld && rr) begin
      last_rdata = rsp_rdata;
      void'(sb_q.pop_front());
      rsp_cnt++;
    end
    if (v && exp_rdy) begin
      chk("ram_en_acc", 32'(ram_en), 32'd1);
      chk("ram_addr", 32'(ram_addr), 32'(a));
      chk("ram_we", 32'(ram_we), 32'(s));
      chk("ram_din", ram_din, d);
      if (s == 4'h0) begin
        sb_q.push_back(ref_mem[a]);
      end else begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      chk("ram_en_idle", 32'(ram_en), 32'd0);
    end
    @(negedge clk);
  endtask

  // Called at the negedge where reset was just released: START + 16 INIT cycles.
  task automatic init_check();
    req_valid = 1'b1; req_addr = 4'hF; req_wstrb = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_req_ready", 32'(req_ready), 32'd0);
      if (i == 0) begin
        chk("start_ram_en", 32'(ram_en), 32'd0);
      end else begin
        chk("init_ram_en", 32'(ram_en), 32'd1);
        chk("init_ram_we", 32'(ram_we), 32'hF);
        chk("init_ram_din", ram_din, 32'h0);
        chk("init_ram_addr", 32'(ram_addr), 32'(i - 1));
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rsp_cnt = 0; ram0_en_cnt = 0; last_rdata = 32'h0;
    arst_n = 1'b0; arst0_n = 1'b0;
    req_valid = 1'b0; req_addr = 4'h0; req_wstrb = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    req_valid0 = 1'b0; req_addr0 = 4'h0; req_wstrb0 = 4'h0; req_wdata0 = 32'h0; rsp_ready0 = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // reset values
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);

    // 1: zero fill after reset
    @(negedge clk);
    arst_n = 1'b1;
    init_check();

    // 2: full write then read-back
    step(1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 4'd3, 4'h0, 32'h0, 1'b1);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    chk("t2_rsp_cnt", 32'(rsp_cnt), 32'd1);
    chk("t2_rdata", last_rdata, 32'hDEAD_BEEF);

    // 3: partial-strobe write over a zeroed word
    step(1'b1, 4'd5, 4'b0101, 32'hAABB_CCDD, 1'b1);
    step(1'b1, 4'd5, 4'h0, 32'h0, 1'b1);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    chk("t3_rdata", last_rdata, 32'h00BB_00DD);

    // 4: stalled response blocks a write to the same word until taken
    step(1'b1, 4'd3, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 4'hF, 32'h1111_1111, 1'b0);
    step(1'b1, 4'd3, 4'hF, 32'h1111_1111, 1'b1);
    chk("t4_rdata", last_rdata, 32'hDEAD_BEEF);
    step(1'b1, 4'd3, 4'h0, 32'h0, 1'b1);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    chk("t4_new_rdata", last_rdata, 32'h1111_1111);
    chk("t4_rsp_cnt", 32'(rsp_cnt), 32'd4);

    // 5: back-to-back writes then back-to-back reads
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 4'hF, 32'hC0DE_0000 + 32'(i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 4'h0, 32'h0, 1'b1);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    chk("t5_rsp_cnt", 32'(rsp_cnt), 32'd12);
    chk("t5_last", last_rdata, 32'hC0DE_0007);

    // 6: reset in the middle of the fill, then a full restart
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    chk("t6_addr9", 32'(ram_addr), 32'd9);
    arst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_ram_en", 32'(ram_en), 32'd0);
    chk("t6_ram_we", 32'(ram_we), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    init_check();
    step(1'b1, 4'd0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 4'd9, 4'h0, 32'h0, 1'b1);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    chk("t6_rdata9", last_rdata, 32'h0);

    // 7: no zero fill configured
    arst0_n = 1'b1;
    #1;
    chk("t7_start_busy", 32'(busy0), 32'd1);
    chk("t7_start_ready", 32'(req_ready0), 32'd0);
    @(negedge clk);
    #1;
    chk("t7_run_busy", 32'(busy0), 32'd0);
    chk("t7_run_ready", 32'(req_ready0), 32'd1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("t7_no_ram_writes", 32'(ram0_en_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
